quad_generator: RTL and testbench



---
 rtl/quad_generator.sv | 121 ++++++++++++
 tb/tb_quad_generator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_generator.sv
// Quadrature A/B generator: converts step commands into Gray-coded A/B
// phase edges, two edges per detent, with position tracking and abort.
module quad_generator #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned POS_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_up,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [DIV_W-1:0] edge_div,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [DIV_W-1:0] TIMER_ONE = DIV_W'(1);
  localparam logic [CNT_W:0]   LEFT_ONE  = (CNT_W+1)'(1);

  state_t           state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [CNT_W:0]   left_q, left_d;
  logic [CNT_W:0]   left_dec;
  logic             edge_hit;
  logic             done_q, done_d;
  logic             a_q, b_q;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    div_d    = div_q;
    timer_d  = timer_q;
    left_d   = left_q;
    left_dec = left_q;
    edge_hit = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            dir_d   = cmd_up;
            div_d   = edge_div;
            left_d  = {cmd_count, 1'b0};
            timer_d = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        edge_hit = (timer_q == div_q);
        if (edge_hit) begin
          timer_d  = '0;
          ph_d     = dir_q ? ph_q + 2'd1 : ph_q - 2'd1;
          // Count on the edge that leaves an even (detent) phase.
          if (!ph_q[0]) pos_d = dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;
          left_dec = left_q - LEFT_ONE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
        // Abort keeps only the edge that completes a half-done detent.
        left_d = abort ? {{CNT_W{1'b0}}, left_dec[0]} : left_dec;
        if (left_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ph_q    <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      div_q   <= '0;
      timer_q <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      left_q  <= left_d;
      done_q  <= done_d;
      a_q     <= ph_d[1] ^ ph_d[0];
      b_q     <= ph_d[1];
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign done      = done_q;
  assign position  = pos_q;
  assign busy      = (state_q == RUN);
  assign cmd_ready = (state_q == IDLE);

endmodule

// File: tb/tb_quad_generator.sv
// Bench for quad_generator: vector table, hand sequences, random soak
// checked each cycle against an edge-schedule model and an A/B decoder.
module tb_quad_generator;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_up;
  logic [7:0] cmd_count;
  logic [15:0] edge_div;
  logic       abort;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic [7:0] position;

  quad_generator #(.CNT_W(8), .DIV_W(16), .POS_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_up(cmd_up), .cmd_count(cmd_count), .edge_div(edge_div), .abort(abort),
    .a(a), .b(b), .busy(busy), .done(done), .position(position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [1:0] ab_of(input int p);
    case (p)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int phase_of(input logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  // Reference model: absolute edge schedule, phase/position as integers.
  bit m_run = 0, m_dir = 0, m_done = 0;
  int m_ph = 0, m_pos = 0, m_left = 0, m_div = 0, m_cyc = 0, m_next = 0, m_edges = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_run = 0; m_ph = 0; m_pos = 0; m_left = 0; m_done = 0; m_cyc = 0;
    end else begin
      m_cyc++;
      m_done = 0;
      if (!m_run) begin
        if (cmd_valid) begin
          if (cmd_count == 0) m_done = 1;
          else begin
            m_run = 1; m_dir = cmd_up; m_left = 2 * int'(cmd_count);
            m_div = int'(edge_div); m_next = m_cyc + m_div + 1;
          end
        end
      end else begin
        if (m_cyc == m_next) begin
          if (m_ph % 2 == 0) m_pos = m_pos + (m_dir ? 1 : -1);
          m_ph = (m_ph + (m_dir ? 1 : 3)) % 4;
          m_left--; m_edges++;
          m_next = m_cyc + m_div + 1;
        end
        if (abort) m_left = m_left % 2;
        if (m_left == 0) begin m_run = 0; m_done = 1; end
      end
    end
  end

  // Cycle checker plus an independent decoder driven only by a/b.
  logic [1:0] dec_prev = 2'b00;
  int dec_val = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] mp;
      int pp, np, d;
      mp = m_pos[7:0];
      check("cycle", {a, b, position, busy, cmd_ready, done},
            {ab_of(m_ph), mp, m_run, !m_run, m_done});
      if ({a, b} != dec_prev) begin
        pp = phase_of(dec_prev);
        np = phase_of({a, b});
        d  = (np - pp + 4) % 4;
        check("gray_step", 32'(d == 1 || d == 3), 32'd1);
        if (pp % 2 == 0) dec_val = dec_val + ((d == 1) ? 1 : -1);
        dec_prev = {a, b};
      end
      check("decoder", 32'(position[1:0]), 32'(dec_val[1:0]));
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    #1;
    check("rst_outputs", {a, b, busy, done, cmd_ready, position}, {5'b00001, 8'h00});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; dec_prev = 2'b00; dec_val = 0;
    @(posedge clk);
    chk_en = 1'b1;
  endtask

  // Called at the negedge after the accepting clock; k counts clocks to done.
  task automatic wait_done(input int limit, input int abort_at, output int k);
    k = 0;
    while (!done) begin
      if (k >= limit) begin k = -1; abort = 1'b0; return; end
      abort = (abort_at != 0 && k + 1 == abort_at);
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    abort = 1'b0;
  endtask

  typedef struct {
    bit         up;
    logic [7:0] count;
    logic [15:0] div;
    int         abort_at;
    logic [1:0] ab;
    logic [7:0] pos;
    int         cyc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int e0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_up = 1'b0; cmd_count = '0;
    edge_div = '0; abort = 1'b0;

    vecs[0]  = '{1, 8'd3,   16'd3,    0, 2'b11, 8'h03, 24};
    vecs[1]  = '{0, 8'd1,   16'd0,    0, 2'b11, 8'hFF, 2};
    vecs[2]  = '{1, 8'd0,   16'd5,    0, 2'b00, 8'h00, 0};
    vecs[3]  = '{1, 8'd4,   16'd1,    6, 2'b00, 8'h02, 8};
    vecs[4]  = '{1, 8'd4,   16'd1,    5, 2'b11, 8'h01, 5};
    vecs[5]  = '{0, 8'd2,   16'd2,    0, 2'b00, 8'hFE, 12};
    vecs[6]  = '{1, 8'd1,   16'd0,    1, 2'b11, 8'h01, 2};
    vecs[7]  = '{1, 8'd255, 16'd0,    0, 2'b11, 8'hFF, 510};
    vecs[8]  = '{0, 8'd128, 16'd0,    0, 2'b00, 8'h80, 256};
    vecs[9]  = '{0, 8'd3,   16'd0,    3, 2'b00, 8'hFE, 4};
    vecs[10] = '{1, 8'd2,   16'd1000, 0, 2'b00, 8'h02, 4004};

    do_reset();

    foreach (vecs[i]) begin
      do_reset();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_up = vecs[i].up; cmd_count = vecs[i].count; edge_div = vecs[i].div;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done(20000, vecs[i].abort_at, k);
      check($sformatf("vec%0d_cycles", i), k, vecs[i].cyc);
      check($sformatf("vec%0d_ab", i), {a, b}, vecs[i].ab);
      check($sformatf("vec%0d_pos", i), position, vecs[i].pos);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_after", i), {done, cmd_ready, busy}, 3'b010);
    end

    // cmd_valid held through RUN with changing fields
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_up = 1'b1; cmd_count = 8'd2; edge_div = 16'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_up = 1'b0; cmd_count = 8'd7; edge_div = 16'd0;
    wait_done(1000, 0, k);
    check("hold_done1", k, 8);
    check("hold_pos1", {a, b, position}, {2'b00, 8'h02});
    @(posedge clk);
    @(negedge clk);
    check("hold_accept_next", {busy, cmd_ready}, 2'b10);
    cmd_valid = 1'b0;
    wait_done(1000, 0, k);
    check("hold_done2", k, 14);
    check("hold_pos2", {a, b, position}, {2'b11, 8'hFB});

    // Reset asserted mid-run, between clock edges
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_up = 1'b1; cmd_count = 8'd10; edge_div = 16'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("midrun_pre", {a, b, busy, position}, {3'b111, 8'h01});
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check("midrun_reset", {a, b, busy, done, position}, 12'h000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; dec_prev = 2'b00; dec_val = 0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset", {cmd_ready, busy, a, b}, 4'b1000);
    chk_en = 1'b1;

    // Random soak: per-cycle random commands, aborts and held valids
    do_reset();
    e0 = m_edges;
    for (int c = 0; c < 20000 && (m_edges - e0) < 600; c++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_up    = 1'($urandom_range(0, 1));
      cmd_count = 8'($urandom_range(0, 4));
      edge_div  = 16'($urandom_range(0, 2));
      abort     = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    check("soak_edges", 32'((m_edges - e0) >= 600), 32'd1);
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
